// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM->WB stage buffer: payload layout, occupancy states, WB value mux.
// Optional forwarding outputs are enabled with the MEM_WB_FWD_EN macro.
package mem_wb_pkg;

  localparam int MEM_WB_DW = 32;
  localparam int MEM_WB_RW = 4;

  typedef struct packed {
    logic                 wb_en;
    logic                 mem_r;
    logic [MEM_WB_DW-1:0] alu_res;
    logic [MEM_WB_DW-1:0] mem_data;
    logic [MEM_WB_RW-1:0] dest;
  } mem_wb_payload_t;

  // Encoding equals the number of valid entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  function automatic logic [MEM_WB_DW-1:0] wb_value(input mem_wb_payload_t p);
    return p.mem_r ? p.mem_data : p.alu_res;
  endfunction

endpackage

// File: rtl/mem_wb_stage_buf_if.sv
// MEM-side and WB-side handshake/payload bundle of the MEM->WB stage buffer.
// fwd_* signals exist only when MEM_WB_FWD_EN is defined.
interface mem_wb_stage_buf_if
  import mem_wb_pkg::*;
#(
  parameter int DW = MEM_WB_DW,
  parameter int RW = MEM_WB_RW
);

  logic          in_valid;
  logic          in_ready;
  logic          wb_en_in;
  logic          mem_r_in;
  logic [DW-1:0] alu_res_in;
  logic [DW-1:0] mem_data_in;
  logic [RW-1:0] dest_in;

  logic          out_valid;
  logic          out_ready;
  logic          wb_en_out;
  logic          mem_r_out;
  logic [DW-1:0] alu_res_out;
  logic [DW-1:0] mem_data_out;
  logic [RW-1:0] dest_out;
  logic [DW-1:0] wb_value_out;

`ifdef MEM_WB_FWD_EN
  logic          fwd_valid;
  logic [RW-1:0] fwd_dest;
  logic [DW-1:0] fwd_value;
`endif

  modport slave (
    input  in_valid, wb_en_in, mem_r_in, alu_res_in, mem_data_in, dest_in, out_ready,
    output in_ready, out_valid, wb_en_out, mem_r_out, alu_res_out, mem_data_out,
           dest_out, wb_value_out
`ifdef MEM_WB_FWD_EN
    , output fwd_valid, fwd_dest, fwd_value
`endif
  );

  modport master (
    output in_valid, wb_en_in, mem_r_in, alu_res_in, mem_data_in, dest_in, out_ready,
    input  in_ready, out_valid, wb_en_out, mem_r_out, alu_res_out, mem_data_out,
           dest_out, wb_value_out
`ifdef MEM_WB_FWD_EN
    , input fwd_valid, fwd_dest, fwd_value
`endif
  );

endinterface

// File: rtl/mem_wb_entry.sv
// One buffer slot: payload register with load enable plus its valid bit, both cleared by async reset.
module mem_wb_entry
  import mem_wb_pkg::*;
#(
  parameter type payload_t = mem_wb_payload_t
)
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  payload_t d,
  input  logic     valid_d,
  output logic     valid,
  output payload_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      valid <= valid_d;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage_buf.sv
// MEM->WB pipeline boundary: 2-entry skid buffer (HEAD drives WB, SKID absorbs back-pressure),
// freeze/flush control and WB value mux. Define MEM_WB_FWD_EN for the EX bypass outputs.
module mem_wb_stage_buf
  import mem_wb_pkg::*;
#(
  parameter int DW = MEM_WB_DW,
  parameter int RW = MEM_WB_RW
)
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                freeze,
  input  logic                flush,
  mem_wb_stage_buf_if.slave   bus
);

  typedef struct packed {
    logic          wb_en;
    logic          mem_r;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] mem_data;
    logic [RW-1:0] dest;
  } payload_t;

  function automatic logic [DW-1:0] wb_sel(input payload_t p);
    return p.mem_r ? p.mem_data : p.alu_res;
  endfunction

  buf_state_t state;
  buf_state_t state_nxt;
  payload_t   in_pl;
  payload_t   head;
  payload_t   skid;
  payload_t   head_d;
  logic       head_valid;
  logic       skid_valid;
  logic       head_load;
  logic       skid_load;
  logic       push;
  logic       pop;

  assign in_pl = '{wb_en:    bus.wb_en_in,
                   mem_r:    bus.mem_r_in,
                   alu_res:  bus.alu_res_in,
                   mem_data: bus.mem_data_in,
                   dest:     bus.dest_in};

  assign bus.in_ready  = ~skid_valid & ~freeze & rst_n;
  assign bus.out_valid = head_valid & ~freeze;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    state_nxt = state;
    head_load = 1'b0;
    skid_load = 1'b0;
    head_d    = in_pl;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = HALF;
          head_load = 1'b1;
        end
      end
      HALF: begin
        if (push && pop) begin
          head_load = 1'b1;
        end else if (push) begin
          state_nxt = FULL;
          skid_load = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt = HALF;
          head_load = 1'b1;
          head_d    = skid;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over everything; payload is left as-is so outputs keep the last HEAD.
    if (flush) begin
      state_nxt = EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  mem_wb_entry #(.payload_t(payload_t)) u_head (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (head_load),
    .d       (head_d),
    .valid_d (state_nxt != EMPTY),
    .valid   (head_valid),
    .q       (head)
  );

  mem_wb_entry #(.payload_t(payload_t)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .d       (in_pl),
    .valid_d (state_nxt == FULL),
    .valid   (skid_valid),
    .q       (skid)
  );

  assign bus.wb_en_out    = head.wb_en & bus.out_valid;
  assign bus.mem_r_out    = head.mem_r;
  assign bus.alu_res_out  = head.alu_res;
  assign bus.mem_data_out = head.mem_data;
  assign bus.dest_out     = head.dest;
  assign bus.wb_value_out = wb_sel(head);

`ifdef MEM_WB_FWD_EN
  // SKID holds the younger result, so it shadows HEAD for the same destination.
  always_comb begin
    bus.fwd_valid = 1'b0;
    bus.fwd_dest  = '0;
    bus.fwd_value = '0;
    if (skid_valid && skid.wb_en) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_dest  = skid.dest;
      bus.fwd_value = wb_sel(skid);
    end else if (head_valid && head.wb_en) begin
      bus.fwd_valid = 1'b1;
      bus.fwd_dest  = head.dest;
      bus.fwd_value = wb_sel(head);
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage_buf.sv
// Bench for mem_wb_stage_buf: queue-based reference model checked every cycle, plus directed literals.
module tb_mem_wb_stage_buf;

  localparam int DW = 32;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic freeze;
  logic flush;

  mem_wb_stage_buf_if #(.DW(DW), .RW(RW)) bus ();

  mem_wb_stage_buf #(.DW(DW), .RW(RW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .freeze (freeze),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wb_en;
    logic          mem_r;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [RW-1:0] dest;
  } ent_t;

  ent_t q[$];
  ent_t last_head = '0;
  int   checks    = 0;
  int   failures  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, {96'b0, act}, {96'b0, exp});
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {127'b0, act}, {127'b0, exp});
  endtask

  // Reference model: an ordered queue of at most two results.
  always @(posedge clk or negedge rst_n) begin
    logic rdy;
    logic ov;
    if (!rst_n) begin
      q.delete();
      last_head = '0;
    end else begin
      rdy = (q.size() < 2) && !freeze;
      ov  = (q.size() > 0) && !freeze;
      if (flush) begin
        q.delete();
      end else begin
        if (ov && bus.out_ready) void'(q.pop_front());
        if (rdy && bus.in_valid)
          q.push_back({bus.wb_en_in, bus.mem_r_in, bus.alu_res_in, bus.mem_data_in, bus.dest_in});
      end
      if (q.size() > 0) last_head = q[0];
    end
  end

  always @(negedge clk) begin
    logic [103:0] act;
    logic [103:0] exp;
    ent_t         h;
    logic         ov;
    logic         ir;
    ov = (q.size() > 0) && !freeze;
    ir = rst_n && (q.size() < 2) && !freeze;
    h  = last_head;
    if (q.size() > 0) h = q[0];
    exp = {ir, ov, h.wb_en & ov, h.mem_r, h.alu, h.mem, h.dest, h.mem_r ? h.mem : h.alu};
    act = {bus.in_ready, bus.out_valid, bus.wb_en_out, bus.mem_r_out, bus.alu_res_out,
           bus.mem_data_out, bus.dest_out, bus.wb_value_out};
    chk("cycle_outputs", {24'b0, act}, {24'b0, exp});
`ifdef MEM_WB_FWD_EN
    begin
      logic          fv;
      logic [RW-1:0] fd;
      logic [DW-1:0] fval;
      logic          found;
      fv = 1'b0; fd = '0; fval = '0; found = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!found && q[i].wb_en) begin
          found = 1'b1;
          fv    = 1'b1;
          fd    = q[i].dest;
          fval  = q[i].mem_r ? q[i].mem : q[i].alu;
        end
      end
      chk("cycle_fwd", {91'b0, fv, fd, fval}, {91'b0, bus.fwd_valid, bus.fwd_dest, bus.fwd_value});
    end
`endif
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_in(input logic v, input logic we, input logic mr,
                        input logic [31:0] a, input logic [31:0] m, input logic [3:0] d);
    bus.in_valid    = v;
    bus.wb_en_in    = we;
    bus.mem_r_in    = mr;
    bus.alu_res_in  = a;
    bus.mem_data_in = m;
    bus.dest_in     = d;
  endtask

  initial begin
    rst_n  = 1'b1;
    freeze = 1'b0;
    flush  = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk1("reset_in_ready", bus.in_ready, 1'b0);
    chk32("reset_wb_value", bus.wb_value_out, 32'h0);
    rst_n = 1'b1;
    #1 chk1("release_in_ready", bus.in_ready, 1'b1);

    // Streaming at full rate
    bus.out_ready = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 4'd5);
    tick();
    chk32("stream_1", bus.wb_value_out, 32'd1);
    chk1("stream_valid", bus.out_valid, 1'b1);
    set_in(1'b1, 1'b1, 1'b0, 32'd2, 32'h0, 4'd5);
    tick();
    chk32("stream_2", bus.wb_value_out, 32'd2);
    set_in(1'b1, 1'b1, 1'b0, 32'd3, 32'h0, 4'd5);
    tick();
    chk32("stream_3", bus.wb_value_out, 32'd3);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    tick();
    chk1("stream_drained", bus.out_valid, 1'b0);
    chk32("stream_stale_head", bus.wb_value_out, 32'd3);

    // Back-pressure fills both slots
    bus.out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'd1);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'd2);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    #1;
    chk1("bp_full_in_ready", bus.in_ready, 1'b0);
    chk32("bp_head_a", bus.wb_value_out, 32'h10);
    bus.out_ready = 1'b1;
    tick();
    chk32("bp_then_b", bus.wb_value_out, 32'h20);
    tick();
    chk1("bp_empty", bus.out_valid, 1'b0);

    // Load result selects memory data
    set_in(1'b1, 1'b1, 1'b1, 32'hAAAA, 32'h5555, 4'd2);
    tick();
    chk32("load_sel", bus.wb_value_out, 32'h5555);
    chk1("load_mem_r", bus.mem_r_out, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    tick();

    // Bubble still needs a pop
    bus.out_ready = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd7);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    #1;
    chk1("bubble_valid", bus.out_valid, 1'b1);
    chk1("bubble_wb_en", bus.wb_en_out, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk1("bubble_popped", bus.out_valid, 1'b0);

    // Freeze holds a full buffer
    bus.out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'd1);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'd2);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    bus.out_ready = 1'b1;
    freeze = 1'b1;
    #1;
    chk1("freeze_out_valid", bus.out_valid, 1'b0);
    chk1("freeze_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("freeze_hold_valid", bus.out_valid, 1'b0);
      chk32("freeze_hold_head", bus.wb_value_out, 32'h10);
    end
    freeze = 1'b0;
    #1;
    chk32("unfreeze_a", bus.wb_value_out, 32'h10);
    chk1("unfreeze_valid", bus.out_valid, 1'b1);
    tick();
    chk32("unfreeze_b", bus.wb_value_out, 32'h20);
    tick();
    chk1("unfreeze_empty", bus.out_valid, 1'b0);

    // Flush discards everything, including the offered C
    bus.out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'd1);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'd2);
    tick();
    flush = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 4'd3);
    tick();
    flush = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    #1;
    chk1("flush_out_valid", bus.out_valid, 1'b0);
    chk1("flush_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    chk1("flush_c_lost", bus.out_valid, 1'b0);

`ifdef MEM_WB_FWD_EN
    // Younger SKID result shadows HEAD for the same destination
    bus.out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'd7, 32'h0, 4'd3);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 32'd9, 32'h0, 4'd3);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    freeze = 1'b1;
    #1;
    chk1("fwd_valid", bus.fwd_valid, 1'b1);
    chk32("fwd_dest", {28'b0, bus.fwd_dest}, 32'd3);
    chk32("fwd_value", bus.fwd_value, 32'd9);
    freeze = 1'b0;
    flush  = 1'b1;
    tick();
    flush = 1'b0;
    #1 chk1("fwd_after_flush", bus.fwd_valid, 1'b0);
`endif

    // Reset while full
    bus.out_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'd1);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'd2);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    chk1("midrst_in_ready", bus.in_ready, 1'b0);
    chk32("midrst_alu", bus.alu_res_out, 32'h0);
    chk32("midrst_wb_value", bus.wb_value_out, 32'h0);
    tick();
    rst_n = 1'b1;
    #1 chk1("midrst_release_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 4'd4);
    tick();
    chk32("midrst_first_push", bus.wb_value_out, 32'h44);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
